// File: rtl/bp_fe_bp_pkg.sv
// Shared front-end branch-predictor definitions: the in-flight branch entry
// macro and small helpers used by the resolve queue.

// Packages cannot take parameters, so the entry struct is declared by each
// user at its own BHT index width.
`define DECLARE_BP_FE_BRANCH_ENTRY_S(idx_width_mp) \
  typedef struct packed {                          \
    logic [(idx_width_mp)-1:0] idx;                \
    logic                      pred;               \
  } bp_fe_branch_entry_s

`define BP_FE_BRANCH_ENTRY_WIDTH(idx_width_mp) ((idx_width_mp) + 1)

package bp_fe_bp_pkg;

  function automatic logic bp_fe_pred_correct(input logic pred, input logic taken);
    return pred == taken;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file storage with a combinational read port.

module bsg_mem_1r1w #(
  parameter int width_p = 1,
  parameter int els_p   = 2,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // NOTE: storage has no reset; validity is tracked by the owner's pointers,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_bp_resolve_queue.sv
// Tracks in-flight predicted branches in order and turns each resolution
// into a one-cycle BHT update for the predictor.

module bp_fe_bp_resolve_queue
  import bp_fe_bp_pkg::*;
#(
  parameter bht_idx_width_p = "inv",
  parameter entries_p       = 8,
  localparam ptr_width_lp   = $clog2(entries_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       alloc_v_i,
  input  logic [bht_idx_width_p-1:0] alloc_idx_i,
  input  logic                       alloc_pred_i,
  output logic                       alloc_ready_o,

  input  logic                       resolve_v_i,
  input  logic                       resolve_taken_i,
  input  logic                       flush_i,

  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic                       mispredict_o,
  output logic [ptr_width_lp:0]      count_o,
  output logic                       err_o
);

  `DECLARE_BP_FE_BRANCH_ENTRY_S(bht_idx_width_p);

  localparam int entry_width_lp = `BP_FE_BRANCH_ENTRY_WIDTH(bht_idx_width_p);
  localparam logic [ptr_width_lp:0]   full_count_lp = (ptr_width_lp+1)'(entries_p);
  localparam logic [ptr_width_lp-1:0] ptr_one_lp    = ptr_width_lp'(1);

  bp_fe_branch_entry_s alloc_entry, head_entry;
  logic [entry_width_lp-1:0] head_data;

  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  logic [ptr_width_lp:0]   count_r;

  logic empty, retire, correct_n, squash, alloc_fire;

  assign alloc_entry = '{idx: alloc_idx_i, pred: alloc_pred_i};
  assign head_entry  = bp_fe_branch_entry_s'(head_data);

  bsg_mem_1r1w #(
    .width_p (entry_width_lp),
    .els_p   (entries_p)
  ) entry_mem (
    .w_clk_i  (clk_i),
    .w_v_i    (alloc_fire),
    .w_addr_i (wptr_r),
    .w_data_i (alloc_entry),
    .r_addr_i (rptr_r),
    .r_data_o (head_data)
  );

  assign alloc_ready_o = (count_r != full_count_lp);
  assign count_o       = count_r;

  assign empty      = (count_r == '0);
  assign retire     = resolve_v_i & ~empty & ~flush_i;
  assign correct_n  = bp_fe_pred_correct(head_entry.pred, resolve_taken_i);
  // A mispredict makes every younger entry wrong-path, same as a flush.
  assign squash     = flush_i | (retire & ~correct_n);
  // A full queue never bypasses a same-cycle retire into the freed slot.
  assign alloc_fire = alloc_v_i & alloc_ready_o & ~squash;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r       <= '0;
      wptr_r       <= '0;
      count_r      <= '0;
      w_v_o        <= 1'b0;
      mispredict_o <= 1'b0;
      idx_w_o      <= '0;
      correct_o    <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      w_v_o        <= retire;
      mispredict_o <= retire & ~correct_n;
      if (retire) begin
        idx_w_o   <= head_entry.idx;
        correct_o <= correct_n;
      end
      if (resolve_v_i & empty & ~flush_i) begin
        err_o <= 1'b1;
      end

      if (squash) begin
        rptr_r  <= '0;
        wptr_r  <= '0;
        count_r <= '0;
      end else begin
        if (alloc_fire) wptr_r <= wptr_r + ptr_one_lp;
        if (retire)     rptr_r <= rptr_r + ptr_one_lp;
        count_r <= count_r + (ptr_width_lp+1)'(alloc_fire) - (ptr_width_lp+1)'(retire);
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_resolve_queue.sv
// Randomized and directed bench for the branch resolve queue, checked against
// a queue-based model of in-flight branches.

module tb_bp_fe_bp_resolve_queue;

  localparam int idx_w   = 6;
  localparam int entries = 8;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             alloc_v_i = 1'b0;
  logic [idx_w-1:0] alloc_idx_i = '0;
  logic             alloc_pred_i = 1'b0;
  logic             alloc_ready_o;
  logic             resolve_v_i = 1'b0;
  logic             resolve_taken_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             w_v_o;
  logic [idx_w-1:0] idx_w_o;
  logic             correct_o;
  logic             mispredict_o;
  logic [3:0]       count_o;
  logic             err_o;

  bp_fe_bp_resolve_queue #(
    .bht_idx_width_p (idx_w),
    .entries_p       (entries)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .alloc_v_i       (alloc_v_i),
    .alloc_idx_i     (alloc_idx_i),
    .alloc_pred_i    (alloc_pred_i),
    .alloc_ready_o   (alloc_ready_o),
    .resolve_v_i     (resolve_v_i),
    .resolve_taken_i (resolve_taken_i),
    .flush_i         (flush_i),
    .w_v_o           (w_v_o),
    .idx_w_o         (idx_w_o),
    .correct_o       (correct_o),
    .mispredict_o    (mispredict_o),
    .count_o         (count_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit pred;
  } br_t;

  br_t q[$];
  bit  m_err, m_w_v, m_mp, m_corr;
  int  m_idx;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 0; m_w_v = 0; m_mp = 0; m_corr = 0; m_idx = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_i = 1'b1; alloc_v_i = 1'b0; resolve_v_i = 1'b0; flush_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check("rst_w_v",   w_v_o, 0);
    check("rst_mp",    mispredict_o, 0);
    check("rst_count", count_o, 0);
    check("rst_err",   err_o, 0);
    check("rst_idx",   idx_w_o, 0);
    check("rst_corr",  correct_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("rst_ready", alloc_ready_o, 1);
  endtask

  // One clock of stimulus: drive, apply the model's rules, compare after the edge.
  task automatic step(input bit av, input int ai, input bit ap,
                      input bit rv, input bit rt, input bit fl);
    int  n_before;
    bit  mp;
    br_t h;
    @(negedge clk);
    alloc_v_i = av; alloc_idx_i = idx_w'(ai); alloc_pred_i = ap;
    resolve_v_i = rv; resolve_taken_i = rt; flush_i = fl;
    #1;
    n_before = q.size();
    check("ready", alloc_ready_o, int'(n_before != entries));

    m_w_v = 0; m_mp = 0; mp = 0;
    if (fl) begin
      q.delete();
    end else begin
      if (rv) begin
        if (n_before == 0) m_err = 1;
        else begin
          h = q.pop_front();
          m_w_v  = 1;
          m_idx  = h.idx;
          m_corr = (h.pred == rt);
          m_mp   = !m_corr;
          mp     = m_mp;
          if (mp) q.delete();
        end
      end
      if (av && n_before != entries && !mp) q.push_back('{idx: ai, pred: ap});
    end

    @(posedge clk);
    #1;
    check("w_v",   w_v_o, m_w_v);
    check("mp",    mispredict_o, m_mp);
    check("idx",   idx_w_o, m_idx);
    check("corr",  correct_o, m_corr);
    check("count", count_o, q.size());
    check("err",   err_o, m_err);
  endtask

  initial begin
    model_reset();
    do_reset(2);

    // single correct prediction
    step(1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // fill, overflow attempt, drain in order
    for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);

    // mispredict on the oldest of three, with a same-cycle alloc
    for (int i = 1; i <= 3; i++) step(1, i, 1, 0, 0, 0);
    step(1, 20, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // resolve while empty: sticky error
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    // alloc + resolve on empty queue
    step(1, 11, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    do_reset(1);

    // flush with same-cycle alloc and resolve
    for (int i = 0; i < 3; i++) step(1, i + 30, 1, 0, 0, 0);
    step(1, 40, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    // full queue, retire plus alloc
    for (int i = 0; i < 8; i++) step(1, i + 50, 0, 0, 0, 0);
    step(1, 63, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    do_reset(1);

    // random traffic, mostly-correct predictions so the queue fills at times
    for (int n = 0; n < 3000; n++) begin
      bit av, ap, rv, rt, fl;
      av = ($urandom_range(99) < 60);
      ap = $urandom_range(1);
      rv = ($urandom_range(99) < 40);
      rt = (q.size() > 0 && $urandom_range(99) < 90) ? q[0].pred : 1'($urandom_range(1));
      fl = ($urandom_range(99) < 2);
      step(av, int'($urandom_range(63)), ap, rv, rt, fl);
      if ($urandom_range(999) < 3) do_reset(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
